// File: rtl/imm_gen_pkg.sv
// rtl/imm_gen_pkg.sv - shared opcodes, result kinds and decoded-instruction type for imm_gen_pipe
// The decode helper honours IMM_GEN_W32_EN for the sf=0 forms.
package imm_gen_pkg;

  // Upper nine bits (inst[31:23]) of the 64-bit forms; inst[31] is sf.
  localparam logic [8:0] OP_MOVZ = 9'b110100101;
  localparam logic [8:0] OP_MOVN = 9'b100100101;
  localparam logic [8:0] OP_MOVK = 9'b111100101;
  localparam logic [8:0] OP_ADD  = 9'b100100010;
  localparam logic [8:0] OP_SUB  = 9'b110100010;

  typedef enum logic [2:0] {
    KIND_ILLEGAL      = 3'd0,
    KIND_MOVZ         = 3'd1,
    KIND_MOVN         = 3'd2,
    KIND_MOVK_MERGED  = 3'd3,
    KIND_MOVK_PARTIAL = 3'd4,
    KIND_ADDSUB       = 3'd5
  } kind_e;

  typedef enum logic [2:0] {
    CLS_ILLEGAL = 3'd0,
    CLS_MOVZ    = 3'd1,
    CLS_MOVN    = 3'd2,
    CLS_MOVK    = 3'd3,
    CLS_ADDSUB  = 3'd4
  } cls_e;

  typedef struct packed {
    cls_e        cls;
    logic [1:0]  hw;
    logic [15:0] imm16;
    logic [11:0] imm12;
    logic        sh;
    logic [4:0]  rd;
    logic        sf;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] inst);
    dec_t d;
    logic form_ok;
    d.cls   = CLS_ILLEGAL;
    d.hw    = inst[22:21];
    d.imm16 = inst[20:5];
    d.imm12 = inst[21:10];
    d.sh    = inst[22];
    d.rd    = inst[4:0];
    d.sf    = inst[31];
    case (inst[30:23])
      OP_MOVZ[7:0]: d.cls = CLS_MOVZ;
      OP_MOVN[7:0]: d.cls = CLS_MOVN;
      OP_MOVK[7:0]: d.cls = CLS_MOVK;
      OP_ADD[7:0]:  d.cls = CLS_ADDSUB;
      OP_SUB[7:0]:  d.cls = CLS_ADDSUB;
      default:      d.cls = CLS_ILLEGAL;
    endcase
`ifdef IMM_GEN_W32_EN
    // 32-bit move-wide forms only have lanes 0 and 1.
    form_ok = d.sf || (d.cls == CLS_ADDSUB) || !d.hw[1];
`else
    form_ok = d.sf;
`endif
    if (!form_ok) d.cls = CLS_ILLEGAL;
    return d;
  endfunction

endpackage

// File: rtl/imm_lane_insert.sv
// rtl/imm_lane_insert.sv - replace 16-bit lane hw of a 64-bit base with imm16 (combinational)
module imm_lane_insert (
  input  logic [63:0] base,
  input  logic [1:0]  hw,
  input  logic [15:0] imm16,
  output logic [63:0] result
);

  always_comb begin
    result = base;
    case (hw)
      2'd0: result[15:0]  = imm16;
      2'd1: result[31:16] = imm16;
      2'd2: result[47:32] = imm16;
      default: result[63:48] = imm16;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - two-stage A64 MOVZ/MOVN/MOVK/ADD/SUB immediate generator with MOVK chain merge
// Define IMM_GEN_W32_EN to accept the 32-bit (sf=0) forms; otherwise they report ILLEGAL.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_inst,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_imm,
  output logic [2:0]        out_kind,
  output logic [4:0]        out_rd,
  output logic [TAG_W-1:0]  out_tag
);

  logic             s1_valid;
  dec_t             s1_dec;
  logic [TAG_W-1:0] s1_tag;

  logic             s2_valid;
  kind_e            s2_kind;
  logic [63:0]      s2_val;
  logic [4:0]       s2_rd;
  logic [TAG_W-1:0] s2_tag;
  logic [1:0]       s2_hw;
  logic [15:0]      s2_imm16;
  logic             s2_sf;

  logic             chain_valid;
  logic [63:0]      chain_val;
  logic [4:0]       chain_rd;

  logic             s2_adv;
  logic             s1_adv;
  logic             out_fire;
  logic [63:0]      lane_val;
  logic [63:0]      merge_val;
  kind_e            exp_kind;
  logic [63:0]      exp_val;
  kind_e            res_kind;
  logic [63:0]      res_val;
  logic             merge_hit;

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv && !flush && !rst;
  assign out_fire = s2_valid && out_ready && !flush;

  // Stage 1: capture the decoded instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_dec   <= '0;
      s1_tag   <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_dec <= decode(in_inst);
        s1_tag <= in_tag;
      end
    end
  end

  imm_lane_insert u_lane_expand (
    .base   (64'd0),
    .hw     (s1_dec.hw),
    .imm16  (s1_dec.imm16),
    .result (lane_val)
  );

  // MOVK leaves stage 1 as a partial value; the merge happens against the chain at the output.
  always_comb begin
    exp_kind = KIND_ILLEGAL;
    exp_val  = 64'd0;
    case (s1_dec.cls)
      CLS_MOVZ: begin
        exp_kind = KIND_MOVZ;
        exp_val  = lane_val;
      end
      CLS_MOVN: begin
        exp_kind = KIND_MOVN;
        exp_val  = s1_dec.sf ? ~lane_val : {32'd0, ~lane_val[31:0]};
      end
      CLS_MOVK: begin
        exp_kind = KIND_MOVK_PARTIAL;
        exp_val  = lane_val;
      end
      CLS_ADDSUB: begin
        exp_kind = KIND_ADDSUB;
        exp_val  = s1_dec.sh ? {40'd0, s1_dec.imm12, 12'd0} : {52'd0, s1_dec.imm12};
      end
      default: begin
        exp_kind = KIND_ILLEGAL;
        exp_val  = 64'd0;
      end
    endcase
  end

  // Stage 2: expanded result register driving the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_kind  <= KIND_ILLEGAL;
      s2_val   <= 64'd0;
      s2_rd    <= 5'd0;
      s2_tag   <= '0;
      s2_hw    <= 2'd0;
      s2_imm16 <= 16'd0;
      s2_sf    <= 1'b0;
    end else if (flush) begin
      s2_valid <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_kind  <= exp_kind;
        s2_val   <= exp_val;
        s2_rd    <= s1_dec.rd;
        s2_tag   <= s1_tag;
        s2_hw    <= s1_dec.hw;
        s2_imm16 <= s1_dec.imm16;
        s2_sf    <= s1_dec.sf;
      end
    end
  end

  imm_lane_insert u_lane_merge (
    .base   (chain_val),
    .hw     (s2_hw),
    .imm16  (s2_imm16),
    .result (merge_val)
  );

  // The chain only changes on an output handshake, so this merge is stable while stalled.
  always_comb begin
    merge_hit = (s2_kind == KIND_MOVK_PARTIAL) && chain_valid && (chain_rd == s2_rd);
    res_kind  = s2_kind;
    res_val   = s2_val;
    if (merge_hit) begin
      res_kind = KIND_MOVK_MERGED;
      res_val  = s2_sf ? merge_val : {32'd0, merge_val[31:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_valid <= 1'b0;
      chain_val   <= 64'd0;
      chain_rd    <= 5'd0;
    end else if (flush) begin
      chain_valid <= 1'b0;
    end else if (out_fire) begin
      case (res_kind)
        KIND_MOVZ, KIND_MOVN, KIND_MOVK_MERGED: begin
          chain_valid <= 1'b1;
          chain_val   <= res_val;
          chain_rd    <= s2_rd;
        end
        default: chain_valid <= 1'b0;
      endcase
    end
  end

  assign out_valid = s2_valid;
  assign out_imm   = DATA_W'(res_val);
  assign out_kind  = res_kind;
  assign out_rd    = s2_rd;
  assign out_tag   = s2_tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - directed vectors, stall/reset sequences and randomized model check for imm_gen_pipe
module tb_imm_gen_pipe;

  localparam int DATA_W = 64;
  localparam int TAG_W  = 4;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_inst;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_imm;
  logic [2:0]        out_kind;
  logic [4:0]        out_rd;
  logic [TAG_W-1:0]  out_tag;

  imm_gen_pipe #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inst   (in_inst),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_imm   (out_imm),
    .out_kind  (out_kind),
    .out_rd    (out_rd),
    .out_tag   (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [3:0]  tag;
    bit          flush_first;
    logic [63:0] imm;
    logic [2:0]  kind;
    logic [4:0]  rd;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic [3:0]  tag;
  } item_t;

  // Reference model: architectural rules applied to a whole instruction word.
  logic        m_cv;
  logic [63:0] m_cval;
  logic [4:0]  m_crd;

  task automatic model_out(input logic [31:0] inst, output logic [63:0] imm, output logic [2:0] kind);
    logic [7:0]  op;
    logic        sf;
    int          hw;
    logic [63:0] lane;
    logic [63:0] mask;
    bit          w32;
    bit          is_as;
    bit          ok;
    op   = inst[30:23];
    sf   = inst[31];
    hw   = int'(inst[22:21]);
    lane = 64'(inst[20:5]) << (16 * hw);
    mask = 64'hFFFF << (16 * hw);
`ifdef IMM_GEN_W32_EN
    w32 = 1'b1;
`else
    w32 = 1'b0;
`endif
    is_as = (op == 8'h22) || (op == 8'hA2);
    ok = sf || (w32 && (is_as || hw < 2));
    imm = 64'd0;
    kind = 3'd0;
    if (ok) begin
      case (op)
        8'hA5: begin imm = lane; kind = 3'd1; end
        8'h25: begin imm = ~lane; kind = 3'd2; end
        8'hE5: begin
          if (m_cv && m_crd == inst[4:0]) begin
            imm = (m_cval & ~mask) | lane;
            kind = 3'd3;
          end else begin
            imm = lane;
            kind = 3'd4;
          end
        end
        8'h22, 8'hA2: begin imm = 64'(inst[21:10]) << (inst[22] ? 12 : 0); kind = 3'd5; end
        default: begin imm = 64'd0; kind = 3'd0; end
      endcase
      if (!sf) imm = imm & 64'h0000_0000_FFFF_FFFF;
    end
    if (kind == 3'd1 || kind == 3'd2 || kind == 3'd3) begin
      m_cv = 1'b1;
      m_cval = imm;
      m_crd = inst[4:0];
    end else begin
      m_cv = 1'b0;
    end
  endtask

  function automatic logic [31:0] gen_inst();
    logic [7:0]  op;
    logic        sf;
    logic [1:0]  hw;
    logic [15:0] imm16;
    logic [4:0]  rd;
    int          sel;
    sel   = int'($urandom_range(0, 7));
    sf    = ($urandom_range(0, 3) != 0);
    hw    = 2'($urandom);
    rd    = 5'($urandom_range(0, 3));
    case ($urandom_range(0, 3))
      0: imm16 = 16'h0000;
      1: imm16 = 16'hFFFF;
      default: imm16 = 16'($urandom);
    endcase
    case (sel)
      0, 7: op = 8'hA5;
      1: op = 8'h25;
      2, 3: op = 8'hE5;
      4: op = 8'h22;
      5: op = 8'hA2;
      default: return $urandom;
    endcase
    return {sf, op, hw, imm16, rd};
  endfunction

  // Entered at a falling edge; offers one instruction and checks its result and latency.
  task automatic run_vec(input vec_t v, input int idx);
    bit got;
    int lat;
    in_valid = 1'b0;
    if (v.flush_first) begin
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
    end
    in_valid = 1'b1;
    in_inst = v.inst;
    in_tag = v.tag;
    out_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      #1;
      if (in_ready) got = 1'b1;
      @(negedge clk);
    end
    chk($sformatf("vec%0d_accepted", idx), 64'(got), 64'd1);
    in_valid = 1'b0;
    got = 1'b0;
    lat = 0;
    for (int i = 1; i <= 8 && !got; i++) begin
      #1;
      if (out_valid) begin
        got = 1'b1;
        lat = i;
        chk($sformatf("vec%0d_imm", idx), out_imm, v.imm);
        chk($sformatf("vec%0d_kind", idx), 64'(out_kind), 64'(v.kind));
        chk($sformatf("vec%0d_rd", idx), 64'(out_rd), 64'(v.rd));
        chk($sformatf("vec%0d_tag", idx), 64'(out_tag), 64'(v.tag));
      end
      @(negedge clk);
    end
    chk($sformatf("vec%0d_latency", idx), 64'(lat), 64'd2);
  endtask

  vec_t  vecs[13];
  item_t q[$];
  logic [31:0] st_inst[3];

  initial begin
    logic [63:0] e_imm;
    logic [2:0]  e_kind;
    item_t       it;
    int          acc;
    int          nout;
    logic [DATA_W-1:0] snap_imm;
    logic [TAG_W-1:0]  snap_tag;
    logic [2:0]        snap_kind;
    bit          prev_stall;
    logic [DATA_W-1:0] p_imm;
    logic [2:0]        p_kind;
    logic [4:0]        p_rd;
    logic [TAG_W-1:0]  p_tag;

    vecs[0]  = '{32'hD2A24681, 4'h0, 1'b0, 64'h0000_0000_1234_0000, 3'd1, 5'd1};
    vecs[1]  = '{32'hF297DDE1, 4'h1, 1'b0, 64'h0000_0000_1234_BEEF, 3'd3, 5'd1};
    vecs[2]  = '{32'hF297DDE1, 4'h2, 1'b1, 64'h0000_0000_0000_BEEF, 3'd4, 5'd1};
    vecs[3]  = '{32'h92800002, 4'h3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 3'd2, 5'd2};
    vecs[4]  = '{32'h91400483, 4'h4, 1'b0, 64'h0000_0000_0000_1000, 3'd5, 5'd3};
    vecs[5]  = '{32'hD503201F, 4'h5, 1'b0, 64'h0, 3'd0, 5'd31};
    vecs[6]  = '{32'hD2E24681, 4'h6, 1'b0, 64'h1234_0000_0000_0000, 3'd1, 5'd1};
    vecs[7]  = '{32'hD13FFC07, 4'h7, 1'b0, 64'h0000_0000_0000_0FFF, 3'd5, 5'd7};
`ifdef IMM_GEN_W32_EN
    vecs[8]  = '{32'h52A24681, 4'h8, 1'b0, 64'h0000_0000_1234_0000, 3'd1, 5'd1};
    vecs[9]  = '{32'h12800002, 4'h9, 1'b0, 64'h0000_0000_FFFF_FFFF, 3'd2, 5'd2};
`else
    vecs[8]  = '{32'h52A24681, 4'h8, 1'b0, 64'h0, 3'd0, 5'd1};
    vecs[9]  = '{32'h12800002, 4'h9, 1'b0, 64'h0, 3'd0, 5'd2};
`endif
    vecs[10] = '{32'h72C00021, 4'hA, 1'b0, 64'h0, 3'd0, 5'd1};
    vecs[11] = '{32'hD29FFFE9, 4'hB, 1'b0, 64'h0000_0000_0000_FFFF, 3'd1, 5'd9};
    vecs[12] = '{32'hF2E00009, 4'hC, 1'b0, 64'h0000_0000_0000_FFFF, 3'd3, 5'd9};

    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    in_inst = 32'd0;
    in_tag = '0;
    out_ready = 1'b0;
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd0);
    chk("reset_out_imm", out_imm, 64'd0);
    chk("reset_out_kind", 64'(out_kind), 64'd0);
    chk("reset_out_rd_tag", 64'({out_rd, out_tag}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_reset_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

    // Three inputs against a blocked consumer: two fit, then all drain in order.
    st_inst[0] = 32'h91000401;
    st_inst[1] = 32'h91000802;
    st_inst[2] = 32'h91000C03;
    out_ready = 1'b0;
    acc = 0;
    snap_imm = '0;
    snap_tag = '0;
    snap_kind = '0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1;
      in_inst = st_inst[acc];
      in_tag = 4'(5 + acc);
      #1;
      if (c == 2) begin
        snap_imm = out_imm;
        snap_tag = out_tag;
        snap_kind = out_kind;
      end
      if (c == 3) begin
        chk("stall_in_ready_low", 64'(in_ready), 64'd0);
        chk("stall_out_valid", 64'(out_valid), 64'd1);
        chk("stall_imm_stable", out_imm, snap_imm);
        chk("stall_tag_kind_stable", 64'({out_tag, out_kind}), 64'({snap_tag, snap_kind}));
      end
      if (in_ready) acc++;
      @(negedge clk);
    end
    chk("stall_accepted", 64'(acc), 64'd2);
    out_ready = 1'b1;
    nout = 0;
    for (int c = 0; c < 12 && nout < 3; c++) begin
      in_valid = (acc < 3);
      in_inst = st_inst[acc < 3 ? acc : 2];
      in_tag = 4'(5 + acc);
      #1;
      if (out_valid && out_ready) begin
        chk($sformatf("drain%0d_imm", nout), out_imm, 64'(nout + 1));
        chk($sformatf("drain%0d_tag", nout), 64'(out_tag), 64'(5 + nout));
        nout++;
      end
      if (in_valid && in_ready) acc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("drain_count", 64'(nout), 64'd3);

    // Reset with both stages full, then MOVK to the previously chained register.
    run_vec('{32'hD2800AA5, 4'h1, 1'b0, 64'h55, 3'd1, 5'd5}, 20);
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      in_inst = st_inst[acc];
      in_tag = 4'(acc);
      #1;
      if (in_ready) acc++;
      if (c < 2) @(negedge clk);
    end
    chk("fill_accepted", 64'(acc), 64'd2);
    chk("fill_out_valid", 64'(out_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    chk("midrst_out_imm", out_imm, 64'd0);
    chk("midrst_kind_rd_tag", 64'({out_kind, out_rd, out_tag}), 64'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("after_rst_in_ready", 64'(in_ready), 64'd1);
    chk("after_rst_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    run_vec('{32'hF297DDE5, 4'h3, 1'b0, 64'hBEEF, 3'd4, 5'd5}, 21);

    // Randomized traffic against the reference model.
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    m_cv = 1'b0;
    m_cval = 64'd0;
    m_crd = 5'd0;
    q.delete();
    prev_stall = 1'b0;
    p_imm = '0;
    p_kind = '0;
    p_rd = '0;
    p_tag = '0;
    for (int c = 0; c < 3000; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_inst = gen_inst();
      in_tag = 4'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 99) == 0);
      #1;
      if (prev_stall) begin
        checks++;
        if (!out_valid || out_imm !== p_imm || out_kind !== p_kind || out_rd !== p_rd || out_tag !== p_tag) begin
          failures++;
          $display("FAIL rand_hold cycle=%0d actual=%b/%h/%0d/%0d/%h required=1/%h/%0d/%0d/%h", c, out_valid, out_imm, out_kind, out_rd, out_tag, p_imm, p_kind, p_rd, p_tag);
        end
      end
      if (flush) begin
        chk("rand_flush_in_ready", 64'(in_ready), 64'd0);
        q.delete();
        m_cv = 1'b0;
      end else begin
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            chk("rand_unexpected_output", 64'(out_valid), 64'd0);
          end else begin
            it = q.pop_front();
            model_out(it.inst, e_imm, e_kind);
            chk($sformatf("rand_imm inst=%h", it.inst), out_imm, e_imm);
            chk($sformatf("rand_kind inst=%h", it.inst), 64'(out_kind), 64'(e_kind));
            chk($sformatf("rand_rd inst=%h", it.inst), 64'(out_rd), 64'(it.inst[4:0]));
            chk($sformatf("rand_tag inst=%h", it.inst), 64'(out_tag), 64'(it.tag));
          end
        end
        if (in_valid && in_ready) q.push_back('{in_inst, in_tag});
      end
      prev_stall = out_valid && !out_ready && !flush;
      p_imm = out_imm;
      p_kind = out_kind;
      p_rd = out_rd;
      p_tag = out_tag;
      @(negedge clk);
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("drain_unexpected_output", 64'(out_valid), 64'd0);
        end else begin
          it = q.pop_front();
          model_out(it.inst, e_imm, e_kind);
          chk($sformatf("drain_imm inst=%h", it.inst), out_imm, e_imm);
          chk($sformatf("drain_kind inst=%h", it.inst), 64'(out_kind), 64'(e_kind));
          chk($sformatf("drain_tag inst=%h", it.inst), 64'(out_tag), 64'(it.tag));
        end
      end
      @(negedge clk);
    end
    chk("rand_queue_empty", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning output immediate width; legal values are 64 or more, and bits above 63 are always zero.
REQ-002 SHALL have parameter TAG_W, default 4, meaning the width of a sideband tag carried unchanged from input to output.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port flush, input, 1 bit: synchronous pipeline and chain clear.
REQ-006 SHALL have port in_valid, input, 1 bit: instruction offered.
REQ-007 SHALL have port in_ready, output, 1 bit: instruction accepted this cycle when in_valid is also high.
REQ-008 SHALL have port in_inst, input, 32 bits: A64 instruction word.
REQ-009 SHALL have port in_tag, input, TAG_W bits: sideband tag.
REQ-010 SHALL have port out_valid, output, 1 bit: result present.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-012 SHALL have port out_imm, output, DATA_W bits: expanded immediate.
REQ-013 SHALL have port out_kind, output, 3 bits: result class per REQ-018.
REQ-014 SHALL have port out_rd, output, 5 bits: destination register field inst[4:0].
REQ-015 SHALL have port out_tag, output, TAG_W bits: tag travelling with the result.

Function
REQ-016 SHALL decode the 64-bit forms on inst[31:23]:
- MOVZ = 110100101
- MOVN = 100100101
- MOVK = 111100101
- ADD imm = 100100010
- SUB imm = 110100010
REQ-017 SHALL expand each form as follows:
- MOVZ: imm16 (inst[20:5]) << 16*hw, where hw = inst[22:21].
- MOVN: the bitwise inverse, over 64 bits, of the MOVZ value.
- ADD/SUB: imm12 (inst[21:10]) << (inst[22] ? 12 : 0).
REQ-018 SHALL encode out_kind as:
- 0 = ILLEGAL/other, with out_imm = 0
- 1 = MOVZ
- 2 = MOVN
- 3 = MOVK_MERGED
- 4 = MOVK_PARTIAL
- 5 = ADDSUB
REQ-019 SHALL keep a constant-chain register holding a chain value, a chain Rd and a chain-valid bit.
REQ-020 SHALL resolve MOVK at the output stage:
- Chain valid and Rd equal: out_imm is the chain value with the 16-bit lane hw replaced by imm16, and kind is 3.
- Otherwise: out_imm is imm16 << 16*hw, and kind is 4.
REQ-021 SHALL update the chain only on an output handshake (out_valid && out_ready):
- MOVZ, MOVN or merged MOVK: load out_imm and Rd, and set chain-valid.
- Partial MOVK, ADDSUB or ILLEGAL: clear chain-valid.
REQ-022 SHALL be a two-stage pipeline: stage 1 decodes, stage 2 expands, merges and drives the outputs.
REQ-023 SHALL present a result on the outputs 2 cycles after input acceptance when unstalled, at a throughput of 1 per cycle.
REQ-024 SHALL advance stage 2 when it is empty or when out_ready is high.
REQ-025 SHALL advance stage 1 when stage 1 is empty or stage 2 advances.
REQ-026 SHALL drive in_ready as "stage 1 advances", and in_ready is low while flush is high.
REQ-027 SHALL hold out_imm, out_kind, out_rd and out_tag stable while out_valid is high and out_ready is low.
REQ-028 SHALL make out_valid independent of out_ready (no combinational path from out_ready to out_valid).
REQ-029 SHALL, when flush is high at an edge, clear both stage valids and chain-valid; flush wins over a simultaneous input or output handshake, and the result on out is dropped.
REQ-030 SHALL apply a back-to-back MOVZ then MOVK to the same Rd so that the MOVK merges with the MOVZ result once the MOVZ has been accepted.

Reset
REQ-031 SHALL, on rst asserted, immediately drive out_valid=0, in_ready=0, out_imm=0, out_kind=0, out_rd=0, out_tag=0, clear all stage valids and chain-valid, and set the chain value to 0.
REQ-032 SHALL discard in-flight instructions when reset is asserted mid-operation, and raise in_ready in the first cycle after rst deasserts.

Configuration
REQ-033 SHALL, with IMM_GEN_W32_EN defined, accept the sf=0 forms (inst[31]=0 variants of REQ-016):
- hw must be 0 or 1.
- The result is computed in 32 bits and zero-extended; MOVN inverts 32 bits only.
- hw of 2 or 3 is ILLEGAL.
REQ-034 SHALL, without IMM_GEN_W32_EN, report every sf=0 form as ILLEGAL, kind 0.

Structure
REQ-035 SHALL place the opcode constants, the out_kind enumeration and the decoded-instruction struct (class, hw, imm16/imm12, sh, rd, sf) in shared package imm_gen_pkg.
REQ-036 SHALL use one sub-module, imm_lane_insert, which computes the 16-bit lane shift and insert (a combinational helper).

Verification
REQ-037 SHALL cover: in 0xD2A24681 (MOVZ X1,#0x1234,LSL#16) -> 2 cycles later out_imm=0x12340000, kind=1, rd=1.
REQ-038 SHALL cover: the previous instruction accepted, then 0xF297DDE1 (MOVK X1,#0xBEEF) -> out_imm=0x1234BEEF, kind=3; after a flush the same word gives 0xBEEF, kind=4.
REQ-039 SHALL cover: 0x92800002 (MOVN X2,#0) -> out_imm=0xFFFFFFFFFFFFFFFF, kind=2.
REQ-040 SHALL cover: 0x91400483 (ADD X3,X4,#1,LSL#12) -> out_imm=0x1000, kind=5; 0xD503201F (NOP) -> kind=0, out_imm=0.
REQ-041 SHALL cover: three consecutive inputs with out_ready=0 for 4 cycles -> exactly two accepted, in_ready low, outputs stable, and all three emitted in order with tags preserved once out_ready rises.
REQ-042 SHALL cover: rst pulsed with both stages full -> out_valid=0 immediately, and the next MOVK to a prior Rd yields kind=4.
